// File: rtl/tl_denied_responder.sv
// tl_denied_responder: default TileLink slave that absorbs any A request and answers with a denied D response
module tl_denied_responder #(
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 3,
  parameter int SOURCE_W = 4,
  parameter int ADDR_W   = 32,
  parameter bit DENY     = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [2:0]            a_opcode_i,
  input  logic [2:0]            a_param_i,
  input  logic [SIZE_W-1:0]     a_size_i,
  input  logic [SOURCE_W-1:0]   a_source_i,
  input  logic [ADDR_W-1:0]     a_address_i,
  input  logic [DATA_W/8-1:0]   a_mask_i,
  input  logic [DATA_W-1:0]     a_data_i,
  output logic                  d_valid_o,
  input  logic                  d_ready_i,
  output logic [2:0]            d_opcode_o,
  output logic [1:0]            d_param_o,
  output logic [SIZE_W-1:0]     d_size_o,
  output logic [SOURCE_W-1:0]   d_source_o,
  output logic                  d_sink_o,
  output logic                  d_denied_o,
  output logic                  d_corrupt_o,
  output logic [DATA_W-1:0]     d_data_o,
  input  logic                  e_valid_i,
  output logic                  e_ready_o
);
  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int LOG_BB     = $clog2(BEAT_BYTES);
  // wide enough for the largest burst the size field can express
  localparam int CNT_W      = 1 << SIZE_W;
  localparam logic [SIZE_W-1:0] LOG_BB_S = SIZE_W'(LOG_BB);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ABSORB, RESP, WAIT_E} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            dop_q, dop_d;
  logic [SIZE_W-1:0]     size_q, size_d;
  logic [SOURCE_W-1:0]   src_q, src_d;

  logic [2:0]            in_dop;
  logic [CNT_W-1:0]      in_abeats, in_dbeats, q_dbeats;
  logic                  last;
  logic                  unused_ok;

  function automatic logic [CNT_W-1:0] beats(input logic [SIZE_W-1:0] s);
    return (s <= LOG_BB_S) ? ONE : ONE << (s - LOG_BB_S);
  endfunction

  function automatic logic [2:0] map_op(input logic [2:0] op);
    return (op <= 3'd1) ? 3'd0 : (op <= 3'd4) ? 3'd1 : (op == 3'd5) ? 3'd2 : 3'd4;
  endfunction

  assign in_dop    = map_op(a_opcode_i);
  assign in_abeats = a_opcode_i[2] ? ONE : beats(a_size_i);
  assign in_dbeats = (in_dop == 3'd1) ? beats(a_size_i) : ONE;
  assign q_dbeats  = (dop_q == 3'd1) ? beats(size_q) : ONE;
  assign last      = cnt_q == ONE;

  assign a_ready_o   = (state_q == IDLE) || (state_q == ABSORB);
  assign d_valid_o   = state_q == RESP;
  assign d_opcode_o  = dop_q;
  assign d_param_o   = (dop_q == 3'd4) ? 2'd2 : 2'd0;
  assign d_size_o    = size_q;
  assign d_source_o  = src_q;
  assign d_sink_o    = 1'b0;
  assign d_denied_o  = DENY;
  assign d_corrupt_o = DENY && (dop_q == 3'd1);
  assign d_data_o    = '0;
  assign e_ready_o   = 1'b1;
  assign unused_ok   = ^{a_param_i, a_address_i, a_mask_i, a_data_i};

  // next-state: latch the request header, count A beats in, then D beats out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dop_d   = dop_q;
    size_d  = size_q;
    src_d   = src_q;
    unique case (state_q)
      IDLE: if (a_valid_i) begin
        dop_d   = in_dop;
        size_d  = a_size_i;
        src_d   = a_source_i;
        state_d = (in_abeats == ONE) ? RESP : ABSORB;
        cnt_d   = (in_abeats == ONE) ? in_dbeats : in_abeats - ONE;
      end
      ABSORB: if (a_valid_i) begin
        state_d = last ? RESP : ABSORB;
        cnt_d   = last ? q_dbeats : cnt_q - ONE;
      end
      RESP: if (d_ready_i) begin
        state_d = last ? ((dop_q == 3'd4) ? WAIT_E : IDLE) : RESP;
        cnt_d   = cnt_q - ONE;
      end
      WAIT_E: if (e_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and response fields, cleared asynchronously so a burst can be abandoned anywhere
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dop_q   <= '0;
      size_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dop_q   <= dop_d;
      size_q  <= size_d;
      src_q   <= src_d;
    end
  end
endmodule

// File: tb/tb_tl_denied_responder.sv
// tb_tl_denied_responder: directed checks of the denied responder with hand-computed expectations
module tb_tl_denied_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_sink, d_denied, d_corrupt;
  logic [31:0] d_data;
  logic        e_valid, e_ready;
  int          passed = 0;
  int          total = 0;
  int          fires = 0;
  int          fires0;

  tl_denied_responder dut (
    .clock_i(clk), .reset_i(reset),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode), .a_param_i(a_param),
    .a_size_i(a_size), .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask),
    .a_data_i(a_data),
    .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode), .d_param_o(d_param),
    .d_size_o(d_size), .d_source_o(d_source), .d_sink_o(d_sink), .d_denied_o(d_denied),
    .d_corrupt_o(d_corrupt), .d_data_o(d_data),
    .e_valid_i(e_valid), .e_ready_o(e_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!reset && d_valid && d_ready) fires++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 32'h1000_0000; a_mask = 4'hf; a_data = 32'hdead_beef; d_ready = 0; e_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_dvalid", d_valid, 0);
    chk("rst_dopcode", d_opcode, 0);
    chk("rst_dparam", d_param, 0);
    chk("rst_dsize", d_size, 0);
    chk("rst_dsource", d_source, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_aready", a_ready, 1);
    chk("eready", e_ready, 1);
    e_valid = 1'b1;
    @(negedge clk);
    e_valid = 1'b0;
    chk("stray_e_aready", a_ready, 1);
    chk("stray_e_dvalid", d_valid, 0);
    // Get size 4 -> four AccessAckData beats
    req(3'd4, 3'd4, 4'd3); d_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("get4_dvalid", d_valid, 1);
      chk("get4_opcode", d_opcode, 1);
      chk("get4_size", d_size, 4);
      chk("get4_source", d_source, 3);
      chk("get4_denied", d_denied, 1);
      chk("get4_corrupt", d_corrupt, 1);
      chk("get4_data", d_data, 0);
      chk("get4_aready", a_ready, 0);
      @(negedge clk);
    end
    chk("get4_done_dvalid", d_valid, 0);
    chk("get4_done_aready", a_ready, 1);
    // PutFull size 3 -> two A beats with a gap, one AccessAck
    req(3'd0, 3'd3, 4'd5);
    chk("put_b0_aready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("put_gap_aready", a_ready, 1);
    chk("put_gap_dvalid", d_valid, 0);
    @(negedge clk);
    a_valid = 1'b1;
    chk("put_b1_aready", a_ready, 1);
    chk("put_b1_dvalid", d_valid, 0);
    @(negedge clk);
    a_valid = 1'b0;
    chk("put_dvalid", d_valid, 1);
    chk("put_opcode", d_opcode, 0);
    chk("put_corrupt", d_corrupt, 0);
    chk("put_param", d_param, 0);
    chk("put_size", d_size, 3);
    chk("put_source", d_source, 5);
    chk("put_aready", a_ready, 0);
    @(negedge clk);
    chk("put_done_dvalid", d_valid, 0);
    chk("put_done_aready", a_ready, 1);
    // Hint size 6 -> single HintAck
    req(3'd5, 3'd6, 4'd7);
    @(negedge clk);
    a_valid = 1'b0;
    chk("hint_dvalid", d_valid, 1);
    chk("hint_opcode", d_opcode, 2);
    chk("hint_size", d_size, 6);
    chk("hint_source", d_source, 7);
    chk("hint_corrupt", d_corrupt, 0);
    @(negedge clk);
    chk("hint_done_dvalid", d_valid, 0);
    chk("hint_done_aready", a_ready, 1);
    // AcquireBlock -> Grant, then wait for GrantAck
    req(3'd6, 3'd6, 4'd1);
    @(negedge clk);
    a_valid = 1'b0;
    chk("grant_dvalid", d_valid, 1);
    chk("grant_opcode", d_opcode, 4);
    chk("grant_param", d_param, 2);
    chk("grant_sink", d_sink, 0);
    chk("grant_source", d_source, 1);
    chk("grant_corrupt", d_corrupt, 0);
    @(negedge clk);
    chk("waite_dvalid", d_valid, 0);
    chk("waite_aready0", a_ready, 0);
    @(negedge clk);
    chk("waite_aready1", a_ready, 0);
    e_valid = 1'b1;
    chk("waite_aready_e", a_ready, 0);
    @(negedge clk);
    e_valid = 1'b0;
    chk("grantack_aready", a_ready, 1);
    // Get size 3 with backpressure on both beats
    fires0 = fires;
    req(3'd4, 3'd3, 4'd2); d_ready = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall0_dvalid", d_valid, 1);
      chk("stall0_opcode", d_opcode, 1);
      chk("stall0_size", d_size, 3);
      chk("stall0_source", d_source, 2);
      if (i == 3) d_ready = 1'b1;
      @(negedge clk);
    end
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall1_dvalid", d_valid, 1);
      chk("stall1_opcode", d_opcode, 1);
      chk("stall1_size", d_size, 3);
      chk("stall1_source", d_source, 2);
      if (i == 2) d_ready = 1'b1;
      @(negedge clk);
    end
    chk("stall_done_dvalid", d_valid, 0);
    chk("stall_done_aready", a_ready, 1);
    chk("stall_fires", fires - fires0, 2);
    // reset during the 2nd beat of a 4-beat AccessAckData
    req(3'd4, 3'd4, 4'd3);
    @(negedge clk);
    a_valid = 1'b0;
    chk("rstmid_b0_dvalid", d_valid, 1);
    @(negedge clk);
    chk("rstmid_b1_dvalid", d_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_dvalid", d_valid, 0);
    chk("rstmid_opcode", d_opcode, 0);
    chk("rstmid_size", d_size, 0);
    chk("rstmid_source", d_source, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_aready", a_ready, 1);
    chk("post_rst_dvalid", d_valid, 0);
    req(3'd4, 3'd2, 4'd9);
    @(negedge clk);
    a_valid = 1'b0;
    chk("fresh_dvalid", d_valid, 1);
    chk("fresh_opcode", d_opcode, 1);
    chk("fresh_size", d_size, 2);
    chk("fresh_source", d_source, 9);
    chk("fresh_corrupt", d_corrupt, 1);
    @(negedge clk);
    chk("fresh_done_dvalid", d_valid, 0);
    chk("fresh_done_aready", a_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
